// File: rtl/skolem_ic_sequencer.sv
// Skolem witness sequencer for the invertibility condition bvsge(bvurem(x,s),t).
// For each accepted (s,t) job the block:
//   1. builds a witness x one bit per cycle from an external combinational Skolem netlist,
//   2. divides x by s with a bit-serial restoring divider (MSB first),
//   3. compares the remainder against t as signed values,
//   4. holds x, the remainder and the verdict until the consumer takes them.
module skolem_ic_sequencer #(
  parameter int W    = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    s_in,
  input  logic [W-1:0]    t_in,
  output logic [W-1:0]    sk_s,
  output logic [W-1:0]    sk_t,
  output logic [IDXW-1:0] sk_idx,
  input  logic            sk_bit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    x_out,
  output logic [W-1:0]    rem_out,
  output logic            ic_ok
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUILD = 3'd1,
    DIV   = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(W - 1);

  state_t          state_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [W-1:0]    sk_s_reg;
  logic [W-1:0]    sk_t_reg;
  logic [IDXW-1:0] sk_idx_reg;
  logic [W-1:0]    x_reg;
  logic [W-1:0]    rem_reg;
  logic [IDXW-1:0] div_cnt_reg;
  logic [W-1:0]    x_out_reg;
  logic [W-1:0]    rem_out_reg;
  logic            ic_ok_reg;

  // Witness with the currently requested bit replaced by the Skolem output.
  logic [W-1:0]    x_next;

  // One restoring-division step. The shifted partial remainder needs W+1 bits
  // because the previous remainder can be as large as s-1 (up to 2^W-2).
  logic [W:0]      div_shift;
  logic            div_ge;
  logic [W-1:0]    rem_next;

  // Final remainder: x urem 0 is defined as x.
  logic [W-1:0]    rem_final;
  logic            ic_next;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sk_s      = sk_s_reg;
  assign sk_t      = sk_t_reg;
  assign sk_idx    = sk_idx_reg;
  assign x_out     = x_out_reg;
  assign rem_out   = rem_out_reg;
  assign ic_ok     = ic_ok_reg;

  // Per-bit witness update: only the bit addressed by sk_idx takes the Skolem value.
  for (genvar gi = 0; gi < W; gi++) begin : g_xbit
    assign x_next[gi] = (sk_idx_reg == IDXW'(gi)) ? sk_bit : x_reg[gi];
  end

  // Restoring divider datapath; div_cnt_reg addresses the dividend bit, MSB first.
  always_comb begin
    div_shift = {rem_reg, x_reg[div_cnt_reg]};
    div_ge    = (div_shift >= {1'b0, sk_s_reg});
    rem_next  = div_ge ? W'(div_shift - {1'b0, sk_s_reg}) : div_shift[W-1:0];
  end

  // Remainder selection and signed comparison against t.
  always_comb begin
    rem_final = (sk_s_reg == '0) ? x_reg : rem_reg;
    ic_next   = ($signed(rem_final) >= $signed(sk_t_reg));
  end

  // Sequencer FSM with all outputs registered; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      sk_s_reg      <= '0;
      sk_t_reg      <= '0;
      sk_idx_reg    <= '0;
      x_reg         <= '0;
      rem_reg       <= '0;
      div_cnt_reg   <= '0;
      x_out_reg     <= '0;
      rem_out_reg   <= '0;
      ic_ok_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sk_s_reg     <= s_in;
            sk_t_reg     <= t_in;
            x_reg        <= '0;
            sk_idx_reg   <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= BUILD;
          end
        end

        BUILD: begin
          x_reg <= x_next;
          if (sk_idx_reg == LAST_IDX) begin
            sk_idx_reg  <= '0;
            rem_reg     <= '0;
            div_cnt_reg <= LAST_IDX;
            state_reg   <= DIV;
          end else begin
            sk_idx_reg <= sk_idx_reg + 1'b1;
          end
        end

        DIV: begin
          rem_reg <= rem_next;
          if (div_cnt_reg == '0) begin
            state_reg <= CMP;
          end else begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
          end
        end

        CMP: begin
          x_out_reg     <= x_reg;
          rem_out_reg   <= rem_final;
          ic_ok_reg     <= ic_next;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_ic_sequencer.sv
// Randomised and directed bench for skolem_ic_sequencer (W=4).
// sk_bit is produced from a per-index table holding the desired witness bits.
module tb_skolem_ic_sequencer;

  localparam int W    = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    s_in;
  logic [W-1:0]    t_in;
  logic [W-1:0]    sk_s;
  logic [W-1:0]    sk_t;
  logic [IDXW-1:0] sk_idx;
  logic            sk_bit;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    x_out;
  logic [W-1:0]    rem_out;
  logic            ic_ok;

  logic [W-1:0]    sk_tbl;
  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;

  skolem_ic_sequencer #(.W(W), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .t_in      (t_in),
    .sk_s      (sk_s),
    .sk_t      (sk_t),
    .sk_idx    (sk_idx),
    .sk_bit    (sk_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .rem_out   (rem_out),
    .ic_ok     (ic_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Skolem netlist stand-in: bit sk_idx of the requested witness.
  assign sk_bit = sk_tbl[sk_idx];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: remainder as integer arithmetic, verdict from signed integer compare.
  function automatic int model_rem(input int s, input int x);
    return (s == 0) ? x : (x % s);
  endfunction

  function automatic int model_ic(input int s, input int t, input int x);
    int r, rs, ts;
    r  = model_rem(s, x);
    rs = (r >= 8) ? r - 16 : r;
    ts = (t >= 8) ? t - 16 : t;
    return (rs >= ts) ? 1 : 0;
  endfunction

  // One full job: accept, latency/index checks, result checks, optional stall, handshake.
  task automatic run_job(input int s, input int t, input int x, input int stall,
                         input bit chk_idx, input bit poke_busy);
    int i, k, er, ei;
    i = 0;
    while (!in_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("idle_wait", i, 0);
    s_in     = W'(s);
    t_in     = W'(t);
    sk_tbl   = W'(x);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_in_ready", int'(in_ready), 0);
    k = 0;
    while (!out_valid && k < 40) begin
      if (chk_idx) begin
        if (k < W) chk("sk_idx_seq", int'(sk_idx), k);
        chk("sk_s_stable", int'(sk_s), s);
        chk("sk_t_stable", int'(sk_t), t);
      end
      @(negedge clk);
      k++;
    end
    chk("latency", k, 2 * W + 1);
    er = model_rem(s, x);
    ei = model_ic(s, t, x);
    chk("x_out", int'(x_out), x);
    chk("rem_out", int'(rem_out), er);
    chk("ic_ok", int'(ic_ok), ei);
    out_ready = 1'b0;
    for (int j = 0; j < stall; j++) begin
      if (poke_busy) begin
        in_valid = 1'b1;
        s_in     = ~W'(s);
        t_in     = ~W'(t);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_x", int'(x_out), x);
      chk("stall_rem", int'(rem_out), er);
      chk("stall_ic", int'(ic_ok), ei);
      chk("stall_sk_s", int'(sk_s), s);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", int'(out_valid), 0);
    chk("post_hs_ready", int'(in_ready), 1);
    $display("job s=%0d t=%0d x=%0d -> x_out=%0d rem_out=%0d ic_ok=%0d",
             s, t, x, x_out, rem_out, ic_ok);
  endtask

  initial begin
    int seen_valid, n_acc, k;
    int acc_cyc[4];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    t_in      = '0;
    sk_tbl    = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_rem_out", int'(rem_out), 0);
    chk("rst_ic_ok", int'(ic_ok), 0);
    chk("rst_sk_idx", int'(sk_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the worked examples.
    run_job(3, 1, 5, 0, 1'b0, 1'b0);
    run_job(0, 15, 8, 0, 1'b0, 1'b0);
    run_job(0, 8, 8, 0, 1'b0, 1'b0);
    run_job(7, 7, 15, 0, 1'b1, 1'b0);
    run_job(5, 2, 11, 5, 1'b1, 1'b1);

    // Reset in the second DIV cycle aborts the job and clears every output.
    s_in     = 4'd6;
    t_in     = 4'd3;
    sk_tbl   = 4'd13;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W + 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_x_out", int'(x_out), 0);
    chk("abort_rem_out", int'(rem_out), 0);
    chk("abort_ic_ok", int'(ic_ok), 0);
    chk("abort_sk_s", int'(sk_s), 0);
    chk("abort_sk_t", int'(sk_t), 0);
    chk("abort_sk_idx", int'(sk_idx), 0);
    seen_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    chk("abort_no_result", seen_valid, 0);
    run_job(6, 3, 13, 1, 1'b0, 1'b0);

    // Randomised jobs with random consumer stalls.
    for (int n = 0; n < 16; n++) begin
      run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end

    // Back-to-back throughput with both handshakes tied high.
    s_in      = 4'd5;
    t_in      = 4'd1;
    sk_tbl    = 4'd14;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_acc     = 0;
    k         = 0;
    while (n_acc < 4 && k < 80) begin
      if (out_valid) begin
        chk("b2b_x_out", int'(x_out), 14);
        chk("b2b_rem_out", int'(rem_out), model_rem(5, 14));
        chk("b2b_ic_ok", int'(ic_ok), model_ic(5, 1, 14));
      end
      if (in_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 4) in_valid = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk("b2b_accepts", n_acc, 4);
    for (int j = 1; j < 4; j++) begin
      chk("b2b_spacing", acc_cyc[j] - acc_cyc[j-1], 2 * W + 3);
      $display("accept %0d at cycle %0d (spacing %0d)", j, acc_cyc[j], acc_cyc[j] - acc_cyc[j-1]);
    end
    in_valid = 1'b0;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain_ready", int'(in_ready), 1);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
